// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: ALU encodings, MIPS opcode/funct fields, FSM states and fault codes
package multicycle_control_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR
    } cls_t;

endpackage

// File: rtl/multicycle_control_instr_decode.sv
// instr_decode: maps IR fields to instruction class, ALU op, ALU B source, destination and illegal flag
module instr_decode
    import multicycle_control_pkg::*;
#(
    parameter int ALU_OP_W   = 3,
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    output cls_t                  cls,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [1:0]            alu_src_b,
    output logic [REG_ADDR_W-1:0] addr_in,
    output logic                  illegal
);

    logic [2:0] op;

    always_comb begin
        cls = C_RALU;
        op = OP_ADD;
        alu_src_b = 2'd0;
        illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: case (funct)
                FN_ADD: op = OP_ADD;
                FN_SUB: op = OP_SUB;
                FN_AND: op = OP_AND;
                FN_OR:  op = OP_OR;
                FN_NOR: op = OP_NOR;
                FN_SLT: op = OP_SLT;
                FN_SLL: begin op = OP_SLL; alu_src_b = 2'd3; end
                FN_SRL: begin op = OP_SRL; alu_src_b = 2'd3; end
                FN_JR:  cls = C_JR;
                default: illegal = 1'b1;
            endcase
            OPC_ADDI: begin cls = C_IALU; alu_src_b = 2'd1; end
            OPC_ANDI: begin cls = C_IALU; op = OP_AND; alu_src_b = 2'd2; end
            OPC_ORI:  begin cls = C_IALU; op = OP_OR; alu_src_b = 2'd2; end
            OPC_LW:   begin cls = C_LW; alu_src_b = 2'd1; end
            OPC_SW:   begin cls = C_SW; alu_src_b = 2'd1; end
            OPC_BEQ:  begin cls = C_BEQ; op = OP_SUB; end
            OPC_BNE:  begin cls = C_BNE; op = OP_SUB; end
            OPC_J:    cls = C_J;
            OPC_JAL:  cls = C_JAL;
            default:  illegal = 1'b1;
        endcase
    end

    assign alu_op  = ALU_OP_W'(op);
    assign addr_in = cls == C_JAL ? REG_ADDR_W'(LINK_REG) : REG_ADDR_W'(opcode == OPC_RTYPE ? rd : rt);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer sharing one memory port,
// with IR latch, memory wait counter and sticky fault reporting.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int REG_ADDR_W  = 5,
    parameter int LINK_REG    = 31,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_in,
    input  logic                  mem_ready,
    input  logic                  zero,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_addr_sel,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  reg_we,
    output logic [1:0]            wb_sel,
    output logic [1:0]            alu_src_b,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic [REG_ADDR_W-1:0] addr_a,
    output logic [REG_ADDR_W-1:0] addr_b,
    output logic [REG_ADDR_W-1:0] addr_in,
    output logic [4:0]            shamt,
    output logic [15:0]           imm16,
    output logic [25:0]           addr26,
    output logic                  is_jump,
    output logic                  is_branch,
    output logic                  instr_done,
    output logic [1:0]            fault
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1) + 1;

    state_t                state, state_nx;
    cls_t                  cls;
    logic [31:0]           ir;
    logic [CW-1:0]         wait_cnt;
    logic [1:0]            fault_nx;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic [1:0]            dec_src_b;
    logic                  illegal, timeout, taken;

    instr_decode #(
        .ALU_OP_W(ALU_OP_W),
        .REG_ADDR_W(REG_ADDR_W),
        .LINK_REG(LINK_REG)
    ) u_dec (
        .opcode(ir[31:26]),
        .funct(ir[5:0]),
        .rt(ir[20:16]),
        .rd(ir[15:11]),
        .cls(cls),
        .alu_op(dec_alu_op),
        .alu_src_b(dec_src_b),
        .addr_in(addr_in),
        .illegal(illegal)
    );

    assign addr_a    = REG_ADDR_W'(ir[25:21]);
    assign addr_b    = REG_ADDR_W'(ir[20:16]);
    assign shamt     = ir[10:6];
    assign imm16     = ir[15:0];
    assign addr26    = ir[25:0];
    assign is_jump   = cls inside {C_J, C_JAL, C_JR};
    assign is_branch = cls inside {C_BEQ, C_BNE};
    assign taken     = cls == C_BEQ ? zero : !zero;
    // Timeout fires on the last allowed wait cycle so a late mem_ready still wins.
    assign timeout   = MEM_TIMEOUT != 0 && wait_cnt == CW'(MEM_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            ir <= '0;
            wait_cnt <= '0;
            fault <= FAULT_NONE;
        end else begin
            state <= state_nx;
            ir <= ir_write ? instr_in : ir;
            wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + CW'(1) : '0;
            fault <= fault_nx;
        end
    end

    always_comb begin
        state_nx = state;
        fault_nx = fault;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src = 2'd0;
        reg_we = 1'b0;
        wb_sel = 2'd0;
        alu_src_b = 2'd0;
        alu_op = ALU_OP_W'(OP_ADD);
        instr_done = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_nx = S_DECODE;
                end else if (timeout) begin
                    state_nx = S_TRAP;
                    fault_nx = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                state_nx = illegal ? S_TRAP : S_EXECUTE;
                fault_nx = illegal ? FAULT_ILLEGAL : fault;
            end
            S_EXECUTE: begin
                alu_op = dec_alu_op;
                alu_src_b = dec_src_b;
                case (cls)
                    C_LW, C_SW: state_nx = S_MEM;
                    C_BEQ, C_BNE: begin
                        pc_write = taken;
                        pc_src = taken ? 2'd1 : 2'd0;
                        instr_done = 1'b1;
                        state_nx = S_FETCH;
                    end
                    C_J, C_JAL: begin
                        pc_write = 1'b1;
                        pc_src = 2'd2;
                        reg_we = cls == C_JAL;
                        wb_sel = cls == C_JAL ? 2'd2 : 2'd0;
                        instr_done = 1'b1;
                        state_nx = S_FETCH;
                    end
                    C_JR: begin
                        pc_write = 1'b1;
                        pc_src = 2'd3;
                        instr_done = 1'b1;
                        state_nx = S_FETCH;
                    end
                    default: state_nx = S_WRITEBACK;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we = cls == C_SW;
                if (mem_ready) begin
                    instr_done = cls == C_SW;
                    state_nx = cls == C_SW ? S_FETCH : S_WRITEBACK;
                end else if (timeout) begin
                    state_nx = S_TRAP;
                    fault_nx = FAULT_TIMEOUT;
                end
            end
            S_WRITEBACK: begin
                reg_we = 1'b1;
                wb_sel = cls == C_LW ? 2'd1 : 2'd0;
                instr_done = 1'b1;
                state_nx = S_FETCH;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences with hand-computed control expectations
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic [31:0] instr_in = '0;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_we;
    logic        is_jump, is_branch, instr_done;
    logic [1:0]  pc_src, wb_sel, alu_src_b, fault;
    logic [2:0]  alu_op;
    logic [4:0]  addr_a, addr_b, addr_in, shamt;
    logic [15:0] imm16;
    logic [25:0] addr26;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .mem_ready(mem_ready), .zero(zero),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .addr_a(addr_a), .addr_b(addr_b),
        .addr_in(addr_in), .shamt(shamt), .imm16(imm16), .addr26(addr26), .is_jump(is_jump),
        .is_branch(is_branch), .instr_done(instr_done), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic z);
        @(negedge clk);
        mem_ready = rdy;
        zero = z;
        #1;
    endtask

    // Releases reset just after a rising edge so the next cyc() is fetch cycle 1.
    task automatic reset_pulse;
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rst_fault", fault, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_addr26", addr26, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_fault", fault, 0);
        check("rst_alu_op", alu_op, OP_ADD);
        check("rst_pc_src", pc_src, 0);
        check("rst_reg_we", reg_we, 0);
        check("rst_ir_write", ir_write, 0);
        check("rst_done", instr_done, 0);
        check("rst_imm16", imm16, 0);
        check("rst_addr_a", addr_a, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        instr_in = 32'h2010FEFE;
        cyc(1, 0);
        check("addi_f_req", mem_req, 1);
        check("addi_f_sel", mem_addr_sel, 0);
        check("addi_f_irw", ir_write, 1);
        check("addi_f_pcw", pc_write, 1);
        cyc(0, 0);
        check("addi_d_req", mem_req, 0);
        check("addi_d_done", instr_done, 0);
        cyc(0, 0);
        check("addi_e_op", alu_op, OP_ADD);
        check("addi_e_srcb", alu_src_b, 1);
        check("addi_e_imm", imm16, 16'hFEFE);
        check("addi_e_done", instr_done, 0);
        cyc(0, 0);
        check("addi_w_we", reg_we, 1);
        check("addi_w_dst", addr_in, 16);
        check("addi_w_sel", wb_sel, 0);
        check("addi_w_done", instr_done, 1);

        instr_in = 32'h0111482A;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0);
            check("slt_wait_req", mem_req, 1);
            check("slt_wait_irw", ir_write, 0);
        end
        cyc(1, 0);
        check("slt_f_req", mem_req, 1);
        check("slt_f_irw", ir_write, 1);
        cyc(0, 0);
        check("slt_d_a", addr_a, 8);
        check("slt_d_b", addr_b, 17);
        check("slt_d_dst", addr_in, 9);
        check("slt_d_fault", fault, 0);
        cyc(0, 0);
        check("slt_e_op", alu_op, OP_SLT);
        check("slt_e_srcb", alu_src_b, 0);
        check("slt_e_done", instr_done, 0);
        cyc(0, 0);
        check("slt_w_we", reg_we, 1);
        check("slt_w_done", instr_done, 1);

        instr_in = 32'h1520FFFD;
        for (int k = 0; k < 2; k++) begin
            cyc(1, k[0]);
            cyc(0, k[0]);
            check("bne_d_br", is_branch, 1);
            check("bne_d_jmp", is_jump, 0);
            cyc(0, k[0]);
            check("bne_e_op", alu_op, OP_SUB);
            check("bne_e_pcw", pc_write, k == 0 ? 1 : 0);
            check("bne_e_src", pc_src, k == 0 ? 1 : 0);
            check("bne_e_we", reg_we, 0);
            check("bne_e_done", instr_done, 1);
        end

        instr_in = 32'h8D0A0004;
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
        check("lw_e_op", alu_op, OP_ADD);
        check("lw_e_srcb", alu_src_b, 1);
        cyc(1, 0);
        check("lw_m_req", mem_req, 1);
        check("lw_m_sel", mem_addr_sel, 1);
        check("lw_m_we", mem_we, 0);
        check("lw_m_done", instr_done, 0);
        cyc(0, 0);
        check("lw_w_we", reg_we, 1);
        check("lw_w_sel", wb_sel, 1);
        check("lw_w_dst", addr_in, 10);
        check("lw_w_done", instr_done, 1);

        instr_in = 32'hAD100000;
        cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
        cyc(1, 0);
        check("sw_m_sel", mem_addr_sel, 1);
        check("sw_m_we", mem_we, 1);
        check("sw_m_rwe", reg_we, 0);
        check("sw_m_done", instr_done, 1);

        instr_in = 32'h0C000010;
        cyc(0, 0);
        check("sw_next_req", mem_req, 1);
        check("sw_next_sel", mem_addr_sel, 0);
        cyc(1, 0);
        check("jal_f_irw", ir_write, 1);
        cyc(0, 0);
        check("jal_d_jmp", is_jump, 1);
        cyc(0, 0);
        check("jal_e_pcw", pc_write, 1);
        check("jal_e_src", pc_src, 2);
        check("jal_e_we", reg_we, 1);
        check("jal_e_sel", wb_sel, 2);
        check("jal_e_dst", addr_in, 31);
        check("jal_e_a26", addr26, 26'h10);
        check("jal_e_done", instr_done, 1);

        instr_in = 32'hFC000000;
        cyc(1, 0);
        cyc(0, 0);
        check("ill_d_fault", fault, 0);
        cyc(1, 0);
        check("ill_fault", fault, 1);
        check("ill_req", mem_req, 0);
        check("ill_irw", ir_write, 0);
        cyc(1, 0);
        check("ill_sticky", fault, 1);
        check("ill_req2", mem_req, 0);
        reset_pulse();

        instr_in = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0);
            check("to_wait_req", mem_req, 1);
            check("to_wait_fault", fault, 0);
        end
        cyc(0, 0);
        check("to_fault", fault, 2);
        check("to_req", mem_req, 0);
        cyc(1, 0);
        check("to_sticky", fault, 2);
        check("to_irw", ir_write, 0);
        reset_pulse();

        cyc(1, 0);
        check("rst_fetch_req", mem_req, 1);
        check("rst_fetch_irw", ir_write, 1);
        check("rst_fetch_fault", fault, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states, so one shared memory port serves both instruction fetch and data.
- Decodes the latched instruction into register addresses, immediates, ALU op and datapath strobes.
- Handshakes with a variable-latency memory and raises a sticky fault on illegal opcodes or memory timeout.

Parameters:
- ALU_OP_W, 3, width of alu_op; encodings are the `OP_* constants in _const.v.
- REG_ADDR_W, 5, register-file address width.
- LINK_REG, 31, destination register for jal.
- MEM_TIMEOUT, 0, maximum wait cycles for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_in  in  32  memory read data, captured into IR during FETCH.
- mem_ready  in  1  memory completion strobe for the current request.
- zero  in  1  ALU zero flag from the datapath.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_write  out  1  one-cycle IR load strobe.
- pc_write  out  1  one-cycle PC update strobe.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = {PC[31:28], addr26, 2'b00}, 3 = register rs.
- reg_we  out  1  register-file write strobe.
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = PC+4 (link).
- alu_src_b  out  2  0 = rt, 1 = sign-extended imm16, 2 = zero-extended imm16, 3 = shamt.
- alu_op  out  ALU_OP_W  ALU operation.
- addr_a, addr_b, addr_in  out  REG_ADDR_W  rs, rt and destination register.
- shamt  out  5  shift amount field.
- imm16  out  16  immediate field.
- addr26  out  26  jump target field.
- is_jump, is_branch  out  1  instruction class, valid from DECODE onward.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- fault  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout; sticky.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = FETCH, IR = 0, wait counter = 0.
  - All strobes 0; alu_op = `OP_ADD; pc_src = 0; fault = 0.
  - Field outputs reflect IR = 0.
- Reset asserted mid-operation abandons the instruction with no partial writes; the first post-reset cycle issues a fetch.
- Field outputs (addr_a = IR[25:21], addr_b = IR[20:16], shamt, imm16, addr26) come combinationally from IR, never from instr_in.
- addr_in is chosen by class:
  - rd for R-type;
  - rt for I-type;
  - LINK_REG for jal.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - On mem_ready: ir_write = 1, pc_write = 1, pc_src = 0; go to DECODE.
- DECODE: classify IR.
  - Unsupported opcode or funct -> TRAP.
  - Otherwise -> EXECUTE.
- EXECUTE:
  - R-type ALU (add, sub, and, or, nor, slt): alu_src_b = 0 -> WRITEBACK.
  - sll/srl: alu_src_b = 3 -> WRITEBACK.
  - addi: alu_src_b = 1. andi/ori: alu_src_b = 2. All -> WRITEBACK.
  - lw/sw: alu_op = `OP_ADD, alu_src_b = 1 -> MEM.
  - beq/bne: alu_op = `OP_SUB.
    - pc_write = 1 with pc_src = 1 iff (beq & zero) | (bne & ~zero).
    - instr_done -> FETCH.
  - j/jal: pc_write = 1, pc_src = 2; jal also does reg_we = 1, wb_sel = 2.
    - instr_done -> FETCH.
  - jr: pc_write = 1, pc_src = 3; instr_done -> FETCH.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = sw.
  - On mem_ready: lw -> WRITEBACK; sw -> instr_done, then FETCH.
- WRITEBACK: reg_we = 1, wb_sel = 1 for lw, else 0; instr_done -> FETCH.
- Latency with zero-wait memory (mem_ready in the request cycle):
  - branch/jump: 3 cycles;
  - R/I ALU and sw: 4 cycles;
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- Timeout:
  - The wait counter resets on each new request.
  - If MEM_TIMEOUT > 0 and the counter reaches MEM_TIMEOUT without mem_ready: fault = 2 -> TRAP.
  - mem_ready in the same cycle the counter hits the limit wins; no fault.
- TRAP:
  - All strobes 0 and mem_req dropped.
  - fault is held; the state is left only by reset.
- Writes to register 0 are still strobed; the register file ignores them.

Decomposition:
- _const.v holds:
  - `OP_* ALU encodings (adding `OP_SUB, `OP_AND, `OP_OR, `OP_NOR, `OP_SLL, `OP_SRL);
  - opcode and funct constants;
  - state encodings;
  - fault codes.
- One combinational sub-module, instr_decode, maps IR to class, alu_op, alu_src_b, addr_in and an illegal flag.
- The FSM, wait counter and IR register live in multicycle_control.

Test Plan:
- addi $s0,$zero,0xFEFE (0x2010FEFE), zero-wait -> instr_done on cycle 4; EXECUTE shows alu_op = `OP_ADD, alu_src_b = 1, imm16 = FEFE; WRITEBACK shows reg_we = 1, addr_in = 16.
- slt $t1,$t0,$s1 (0x0111482A) with mem_ready delayed 3 cycles -> mem_req held 4 cycles; alu_op = `OP_SLT; addr_a = 8, addr_b = 17, addr_in = 9; instr_done on cycle 7.
- bne $t1,$zero,-3 (0x1520FFFD): zero = 0 -> EXECUTE pc_write = 1, pc_src = 1; zero = 1 -> pc_write = 0. instr_done on cycle 3 in both cases.
- lw $t2,4($t0) (0x8D0A0004) then sw (0xAD100000) -> lw MEM has mem_addr_sel = 1, mem_we = 0, then WRITEBACK with wb_sel = 1, addr_in = 10; sw MEM has mem_we = 1 and no reg_we.
- jal 0x10 (0x0C000010) -> EXECUTE shows pc_src = 2, reg_we = 1, wb_sel = 2, addr_in = 31.
- Illegal opcode 0xFC000000 -> fault = 1 after DECODE and mem_req stays 0. Separately with MEM_TIMEOUT = 4 and mem_ready held low -> fault = 2 on the 5th request cycle. rst_n pulse in either case -> fault = 0 and a fetch restarts.
